// File: rtl/packet_queue.sv
// packet_queue: store-and-forward packet FIFO; a packet becomes readable only after its end word.
// Define PACKET_QUEUE_DROP_EN to drop packets that overflow the data RAM instead of backpressuring.
module packet_queue #(
    parameter int DATA_BITS   = 8,
    parameter int LENGTH_BITS = 8,
    parameter int BUFFER_SIZE = 16,
    parameter int MAX_PACKETS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_shift,
    input  logic [DATA_BITS-1:0]   in_data,
    input  logic                   in_end,
    input  logic                   in_abort,
    output logic                   in_full,
    input  logic                   out_pop,
    output logic                   out_nempty,
    output logic [DATA_BITS-1:0]   out_data,
    output logic [LENGTH_BITS-1:0] out_length,
    output logic                   out_start,
    output logic                   out_end,
    output logic [15:0]            drop_count
);
    localparam int AW  = $clog2(BUFFER_SIZE);
    localparam int PW  = AW + 1;
    localparam int DAW = (MAX_PACKETS > 1) ? $clog2(MAX_PACKETS) : 1;
    localparam int DD  = 1 << DAW;
    localparam int CW  = $clog2(MAX_PACKETS + 1);

    logic [DATA_BITS-1:0]   r_mem  [BUFFER_SIZE];
    logic [LENGTH_BITS-1:0] r_desc [DD];

    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_wr_base;
    logic [PW-1:0]          r_rd_ptr;
    logic [LENGTH_BITS-1:0] r_wr_len;
    logic [LENGTH_BITS-1:0] r_rd_idx;
    logic [DAW-1:0]         r_dwr;
    logic [DAW-1:0]         r_drd;
    logic [CW-1:0]          r_dcnt;

    logic [PW-1:0] w_used;
    logic          w_ram_full;
    logic          w_desc_full;
    logic          w_discard;
    logic          w_shift_ok;
    logic          w_commit;
    logic          w_rewind;
    logic          w_pop;
    logic          w_dpop;

    assign w_used      = r_wr_ptr - r_rd_ptr;
    assign w_ram_full  = (w_used == PW'(BUFFER_SIZE));
    assign w_desc_full = (r_dcnt == CW'(MAX_PACKETS));

`ifdef PACKET_QUEUE_DROP_EN
    logic        r_dropping;
    logic [15:0] r_drop_cnt;

    assign in_full    = w_desc_full;
    assign w_discard  = w_ram_full || r_dropping;
    assign drop_count = r_drop_cnt;

    // Once a word is lost the rest of that packet is discarded until its end word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dropping <= 1'b0;
            r_drop_cnt <= '0;
        end else if (in_abort) begin
            r_dropping <= 1'b0;
        end else if (w_shift_ok && w_discard) begin
            if (in_end) begin
                r_dropping <= 1'b0;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end else begin
                r_dropping <= 1'b1;
            end
        end
    end
`else
    assign in_full    = w_ram_full || w_desc_full;
    assign w_discard  = 1'b0;
    assign drop_count = '0;
`endif

    assign w_shift_ok = in_shift && !in_full && !in_abort;
    assign w_commit   = w_shift_ok && in_end && !w_discard;
    assign w_rewind   = in_abort || (w_shift_ok && w_discard && in_end);

    assign out_nempty = (r_dcnt != '0);
    assign out_length = out_nempty ? r_desc[r_drd] : '0;
    assign out_data   = r_mem[r_rd_ptr[AW-1:0]];
    assign out_start  = (r_rd_idx == '0);
    assign out_end    = (r_rd_idx == out_length - 1'b1);
    assign w_pop      = out_pop && out_nempty;
    assign w_dpop     = w_pop && out_end;

    always_ff @(posedge clk) begin
        if (w_shift_ok && !w_discard) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
        if (w_commit) begin
            r_desc[r_dwr] <= r_wr_len + 1'b1;
        end
    end

    // Write side: wr_base marks the first word of the packet still being assembled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_wr_base <= '0;
            r_wr_len  <= '0;
        end else if (w_rewind) begin
            r_wr_ptr <= r_wr_base;
            r_wr_len <= '0;
        end else if (w_shift_ok && !w_discard) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (in_end) begin
                r_wr_base <= r_wr_ptr + 1'b1;
                r_wr_len  <= '0;
            end else begin
                r_wr_len <= r_wr_len + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_rd_idx <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_rd_idx <= w_dpop ? '0 : r_rd_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwr  <= '0;
            r_drd  <= '0;
            r_dcnt <= '0;
        end else begin
            if (w_commit) begin
                r_dwr <= r_dwr + 1'b1;
            end
            if (w_dpop) begin
                r_drd <= r_drd + 1'b1;
            end
            if (w_commit && !w_dpop) begin
                r_dcnt <= r_dcnt + 1'b1;
            end else if (!w_commit && w_dpop) begin
                r_dcnt <= r_dcnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_packet_queue.sv
// Bench for packet_queue: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based packet model.
module tb_packet_queue;
    localparam int BS = 16;
    localparam int MP = 4;
`ifdef PACKET_QUEUE_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_shift = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_end   = 1'b0;
    logic        in_abort = 1'b0;
    logic        out_pop  = 1'b0;
    logic        in_full;
    logic        out_nempty;
    logic [7:0]  out_data;
    logic [7:0]  out_length;
    logic        out_start;
    logic        out_end;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       sh;
        logic [7:0] d;
        logic       e;
        logic       pp;
        logic       x_full;
        logic       x_ne;
        logic [7:0] x_data;
        logic [7:0] x_len;
        logic       x_start;
        logic       x_end;
    } vec_t;

    vec_t       tbl [10];
    int         part[$];
    int         words[$];
    int         lens[$];
    int         idx;
    int         k;
    int         used;
    int         mdrop;
    bit         dropping;
    bit         x_full;
    bit         x_ne;
    bit         sh;
    bit         pp;
    bit         e;
    logic [7:0] d;
    logic [7:0] x_data;
    logic [7:0] x_len;

    packet_queue #(
        .DATA_BITS(8), .LENGTH_BITS(8), .BUFFER_SIZE(BS), .MAX_PACKETS(MP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_shift(in_shift), .in_data(in_data), .in_end(in_end), .in_abort(in_abort),
        .in_full(in_full),
        .out_pop(out_pop), .out_nempty(out_nempty), .out_data(out_data),
        .out_length(out_length), .out_start(out_start), .out_end(out_end),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic xf, input logic xn,
                             input logic [7:0] xd, input logic [7:0] xl,
                             input logic xs, input logic xe);
        chk({tag, ".full"},   32'(in_full),    32'(xf));
        chk({tag, ".nempty"}, 32'(out_nempty), 32'(xn));
        chk({tag, ".length"}, 32'(out_length), 32'(xl));
        chk({tag, ".start"},  32'(out_start),  32'(xs));
        chk({tag, ".end"},    32'(out_end),    32'(xe));
        if (xn) chk({tag, ".data"}, 32'(out_data), 32'(xd));
    endtask

    task automatic drive(input logic s, input logic [7:0] dd, input logic ee,
                         input logic ab, input logic p);
        in_shift = s;
        in_data  = dd;
        in_end   = ee;
        in_abort = ab;
        out_pop  = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 8'(i), (i == n - 1), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_pkt(input string tag, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            chk_state(tag, 1'b0, 1'b1, base + 8'(i), 8'(n), (i == 0), (i == n - 1));
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //          sh    d      e     pp  | full  ne    data   len    start end
        tbl[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd3, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'd3, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'd3, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 8'd3, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'd1, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0);
        chk("reset.drop", 32'(drop_count), 32'd0);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            chk_state($sformatf("vec%0d", i), tbl[i].x_full, tbl[i].x_ne, tbl[i].x_data,
                      tbl[i].x_len, tbl[i].x_start, tbl[i].x_end);
            drive(tbl[i].sh, tbl[i].d, tbl[i].e, 1'b0, tbl[i].pp);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

`ifndef PACKET_QUEUE_DROP_EN
        for (int i = 0; i < BS; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk_state("bfull", 1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0);
        drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state("bfull.blocked", 1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk_state("abort", 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0);
        send_pkt(8'h31, 2);
        pop_pkt("abort.next", 8'h31, 2);
        chk_state("abort.empty", 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0);
`endif

        for (int i = 0; i < MP; i++) begin
            drive(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk_state("maxp", 1'b1, 1'b1, 8'h50, 8'd1, 1'b1, 1'b1);
        drive(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state("maxp.blocked", 1'b1, 1'b1, 8'h50, 8'd1, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        pop_pkt("maxp.r1", 8'h51, 1);
        pop_pkt("maxp.r2", 8'h52, 1);
        pop_pkt("maxp.r3", 8'h53, 1);
        chk_state("maxp.empty", 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0);

        // Randomized run: the model holds partial words, committed words and lengths as queues.
        idx = 0; k = 0; mdrop = 0; dropping = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            used   = part.size() + words.size();
            x_full = DROP ? (lens.size() == MP) : ((used == BS) || (lens.size() == MP));
            x_ne   = (lens.size() != 0);
            x_data = 8'h00;
            x_len  = 8'h00;
            if (x_ne) begin
                x_data = 8'(words[0]);
                x_len  = 8'(lens[0]);
            end
            chk_state("rand", x_full, x_ne, x_data, x_len, (idx == 0), x_ne && (idx == int'(x_len) - 1));
            chk("rand.drop", 32'(drop_count), 32'(mdrop));
            sh = (c < 1000) && ($urandom_range(0, 99) < 60);
            pp = (c >= 1000) || ($urandom_range(0, 99) < 45);
            e  = ((k % 20) inside {2, 4, 6, 7, 10});
            d  = 8'(k);
            drive(sh, d, e, 1'b0, pp);
            tick();
            if (pp && x_ne) begin
                void'(words.pop_front());
                idx++;
                if (idx == lens[0]) begin
                    void'(lens.pop_front());
                    idx = 0;
                end
            end
            if (sh && !x_full) begin
                k++;
                if (DROP && ((used == BS) || dropping)) begin
                    if (e) begin
                        part.delete();
                        dropping = 1'b0;
                        if (mdrop < 65535) mdrop++;
                    end else begin
                        dropping = 1'b1;
                    end
                end else begin
                    part.push_back(int'(d));
                    if (e) begin
                        foreach (part[j]) words.push_back(part[j]);
                        lens.push_back(part.size());
                        part.delete();
                    end
                end
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        send_pkt(8'h61, 3);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h64, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_state("areset", 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0);
        chk("areset.drop", 32'(drop_count), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        send_pkt(8'h71, 2);
        pop_pkt("post_reset", 8'h71, 2);
        chk_state("post_reset.empty", 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0);

`ifdef PACKET_QUEUE_DROP_EN
        send_pkt(8'h80, 10);
        for (int i = 0; i < 10; i++) begin
            chk("drop.full", 32'(in_full), 32'd0);
            drive(1'b1, 8'(8'hA0 + i), (i == 9), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("drop.count", 32'(drop_count), 32'd1);
        chk_state("drop.head", 1'b0, 1'b1, 8'h80, 8'd10, 1'b1, 1'b0);
        send_pkt(8'hC0, 3);
        pop_pkt("drop.p1", 8'h80, 10);
        pop_pkt("drop.p2", 8'hC0, 3);
        chk_state("drop.empty", 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/packet_queue.md
# packet_queue

Store-and-forward packet FIFO that accepts word streams delimited by an end flag. A packet becomes visible at the output only once its final word has been written, and it is presented with its length on the first word. This block is the parametrised successor of the single-stream packet buffer. It adds a separate descriptor queue with configurable depth, the ability to abort a partial packet, and an optional drop-on-overflow mode. It sits between the glove sensor framers and the USB/serial transmit path.

## Interface
- DATA_BITS, 8, width of one data word
- LENGTH_BITS, 8, width of packet length field; BUFFER_SIZE must be ≤ 2^LENGTH_BITS − 1
- BUFFER_SIZE, 16, data RAM depth in words; power of two, ≥ 2
- MAX_PACKETS, 4, descriptor queue depth (committed packets held at once); power of two, ≥ 1
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_shift  in  1  write in_data this cycle
- in_data  in  DATA_BITS  input word
- in_end  in  1  in_data is the last word of the packet
- in_abort  in  1  discard current partial packet
- in_full  out  1  writer must not shift
- out_pop  in  1  consume head word
- out_nempty  out  1  at least one committed packet available
- out_data  out  DATA_BITS  head word (show-ahead)
- out_length  out  LENGTH_BITS  word count of head packet, valid whenever out_nempty
- out_start  out  1  head word is first of its packet
- out_end  out  1  head word is last of its packet
- drop_count  out  16  packets dropped on overflow (saturating)

## Operation
- Data RAM is indexed by pointers of width clog2(BUFFER_SIZE)+1; full/empty are distinguished by the MSB. The pointers are:
  - wr_ptr: next write address.
  - wr_base: start of the uncommitted packet.
  - rd_ptr: head word.
- Each committed packet pushes a descriptor {length} into the descriptor queue. A read offset rd_idx counts words already popped from the head packet.
- Write: when in_shift && !in_full && !in_abort, RAM[wr_ptr] ← in_data, wr_ptr++, and wr_len++.
- Commit: a shift with in_end pushes the descriptor with length wr_len+1. It sets wr_base ← wr_ptr+1 and wr_len ← 0.
- Abort: in_abort sets wr_ptr ← wr_base and wr_len ← 0, and blocks any in_shift in the same cycle. Aborting with no partial packet is a no-op.
- in_full = (used words == BUFFER_SIZE) || (descriptor count == MAX_PACKETS). "Used words" means wr_ptr − rd_ptr, which includes the partial packet.
- Read: out_data = RAM[rd_ptr]. out_start = (rd_idx == 0). out_end = (rd_idx == out_length−1).
- A pop with out_nempty does rd_ptr++ and rd_idx++. When out_end is also set, it pops the descriptor and clears rd_idx. A pop without out_nempty is ignored.
- A packet longer than BUFFER_SIZE is illegal without the drop feature, because it deadlocks the block.

## Timing
- Reset values:
  - in_full 0, out_nempty 0, out_start 1, out_end 0, out_length 0, drop_count 0.
  - out_data is undefined but stable.
  - All pointers and counts are zero.
- Reset mid-packet discards all stored and partial data immediately, with no commit.
- Commit latency: out_nempty rises in the cycle after the clock edge that accepted the end word.
- Pop takes effect on the edge. The next word appears combinationally after that edge.
- in_full and out_nempty derive from registered state only. Space freed by a pop is visible to the writer one cycle later. A commit is visible to the reader one cycle later.
- Simultaneous shift and pop are both honoured. Simultaneous commit and descriptor pop keep the count unchanged.
- Pointer wrap-around is transparent. Packets may straddle the RAM end.
- Single-word packet: out_start and out_end are both 1, and out_length is 1.

## Configuration
- PACKET_QUEUE_DROP_EN defined:
  - in_full only reflects descriptor-queue full.
  - If the data RAM is full when a word is shifted, the word is discarded and the current packet is marked dropped.
  - At its in_end, the packet is rewound as for an abort, no descriptor is pushed, and drop_count increments (saturating at 0xFFFF).
  - Already committed packets are never affected.
- Not defined: overflow is prevented by in_full backpressure, and drop_count is tied to 0.

## Test plan
- Write words 0,1,2 with end on 2; no pop -> out_nempty rises 1 cycle after the end edge, out_length=3, out_start=1, data 0. Pops yield 0,1,2 with out_end on 2, then out_nempty=0.
- BUFFER_SIZE=16: write 16 words without end -> in_full=1 and out_nempty=0. Assert in_abort -> next cycle in_full=0, and no data is ever output.
- MAX_PACKETS=4: write four 1-word packets -> in_full=1 with 4 words used. Pop one -> in_full=0 one cycle later.
- Random shift/pop gating, 20-word cycle stream with ends at indices 2,4,6,7,10 across 1000 cycles -> output sequence and lengths match the reference model, including RAM wrap-around.
- Assert rst_n low mid-packet and mid-read -> all outputs return to reset values asynchronously. A subsequent 2-word packet is output correctly.
- With PACKET_QUEUE_DROP_EN: 10-word packet committed, then a 10-word packet arrives without popping -> second packet dropped, drop_count=1. The first packet is output intact, and a following 3-word packet is output normally.
